// File: rtl/gfet_sweep_controller.sv
// gfet_sweep_controller: 2-D Vgs/Vds bias sweep sequencer with per-point settle, ADC averaging and result streaming
// Ports: clk, rst_n (async active-low); start_i/abort_i sweep control; vgs_*_i/vds_*_i grid config,
// settle_cycles_i, avg_log2_i per-point config; dac_vgs_o/dac_vds_o/dac_load_o bias DACs;
// adc_start_o/adc_done_i/adc_data_i drain-current ADC; res_valid_o/res_ready_i/res_vgs_o/res_vds_o/res_id_o
// result stream; busy_o, done_o, err_timeout_o, sat_o status.
module gfet_sweep_controller #(
  parameter int DAC_W        = 12,
  parameter int ADC_W        = 16,
  parameter int CNT_W        = 10,
  parameter int SETTLE_W     = 16,
  parameter int MAX_AVG_LOG2 = 7,
  parameter int TIMEOUT      = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [DAC_W-1:0]    vgs_start_i,
  input  logic [DAC_W-1:0]    vgs_step_i,
  input  logic [CNT_W-1:0]    vgs_count_i,
  input  logic [DAC_W-1:0]    vds_start_i,
  input  logic [DAC_W-1:0]    vds_step_i,
  input  logic [CNT_W-1:0]    vds_count_i,
  input  logic [SETTLE_W-1:0] settle_cycles_i,
  input  logic [2:0]          avg_log2_i,
  output logic [DAC_W-1:0]    dac_vgs_o,
  output logic [DAC_W-1:0]    dac_vds_o,
  output logic                dac_load_o,
  output logic                adc_start_o,
  input  logic                adc_done_i,
  input  logic [ADC_W-1:0]    adc_data_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [DAC_W-1:0]    res_vgs_o,
  output logic [DAC_W-1:0]    res_vds_o,
  output logic [ADC_W-1:0]    res_id_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_timeout_o,
  output logic                sat_o
);
  localparam int ACC_W = ADC_W + MAX_AVG_LOG2;
  localparam int SMP_W = MAX_AVG_LOG2 + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  typedef enum logic [3:0] {IDLE, LOAD, SETTLE, CONV, WAIT, OUTPUT, NEXT, PARK, DONE} state_t;
  state_t               state_q;
  logic [DAC_W-1:0]     vds_start_q, vgs_step_q, vds_step_q;
  logic [CNT_W-1:0]     vgs_last_q, vds_last_q, vgs_idx_q, vds_idx_q;
  logic [SETTLE_W-1:0]  settle_q, set_cnt_q;
  logic [2:0]           avg_q;
  logic [SMP_W-1:0]     smp_q;
  logic [TMO_W-1:0]     tmo_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                 park_ok_q;
  logic [DAC_W-1:0]     dac_vgs_q, dac_vds_q, res_vgs_q, res_vds_q;
  logic [ADC_W-1:0]     res_id_q;
  logic                 dac_load_q, adc_start_q, res_valid_q, done_q, err_q, sat_q;
  logic [DAC_W:0]       vgs_nxt_d, vds_nxt_d;
  logic signed [ACC_W-1:0] acc_d;
  logic                 smp_last_d;
  logic [2:0]           avg_d;
  // Step is signed; {sat, clamped code}. With one guard bit, a negative sum lands in the
  // top quarter (both MSBs set) and an overflow lands just above 2^DAC_W (MSB set only).
  function automatic logic [DAC_W:0] step_code(input logic [DAC_W-1:0] c, input logic [DAC_W-1:0] s);
    logic [DAC_W:0] sum;
    sum = {1'b0, c} + {s[DAC_W-1], s};
    return sum[DAC_W] ? {1'b1, sum[DAC_W-1] ? {DAC_W{1'b0}} : {DAC_W{1'b1}}} : {1'b0, sum[DAC_W-1:0]};
  endfunction
  assign vgs_nxt_d  = step_code(dac_vgs_q, vgs_step_q);
  assign vds_nxt_d  = step_code(dac_vds_q, vds_step_q);
  assign acc_d      = acc_q + $signed({{MAX_AVG_LOG2{adc_data_i[ADC_W-1]}}, adc_data_i});
  assign smp_last_d = smp_q == (SMP_W'(1) << avg_q) - SMP_W'(1);
  assign avg_d      = (32'(avg_log2_i) > MAX_AVG_LOG2) ? 3'(MAX_AVG_LOG2) : avg_log2_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vds_start_q <= '0;
      vgs_step_q  <= '0;
      vds_step_q  <= '0;
      vgs_last_q  <= '0;
      vds_last_q  <= '0;
      vgs_idx_q   <= '0;
      vds_idx_q   <= '0;
      settle_q    <= '0;
      set_cnt_q   <= '0;
      avg_q       <= '0;
      smp_q       <= '0;
      tmo_q       <= '0;
      acc_q       <= '0;
      park_ok_q   <= 1'b0;
      dac_vgs_q   <= '0;
      dac_vds_q   <= '0;
      res_vgs_q   <= '0;
      res_vds_q   <= '0;
      res_id_q    <= '0;
      dac_load_q  <= 1'b0;
      adc_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      dac_load_q  <= 1'b0;
      adc_start_q <= 1'b0;
      done_q      <= 1'b0;
      if (abort_i && state_q != IDLE && state_q != PARK) begin
        state_q     <= PARK;
        park_ok_q   <= 1'b0;
        res_valid_q <= 1'b0;
        dac_vgs_q   <= '0;
        dac_vds_q   <= '0;
        dac_load_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (start_i) begin
            vds_start_q <= vds_start_i;
            vgs_step_q  <= vgs_step_i;
            vds_step_q  <= vds_step_i;
            vgs_last_q  <= (vgs_count_i == '0) ? '0 : vgs_count_i - CNT_W'(1);
            vds_last_q  <= (vds_count_i == '0) ? '0 : vds_count_i - CNT_W'(1);
            vgs_idx_q   <= '0;
            vds_idx_q   <= '0;
            settle_q    <= settle_cycles_i;
            avg_q       <= avg_d;
            smp_q       <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
            sat_q       <= 1'b0;
            dac_vgs_q   <= vgs_start_i;
            dac_vds_q   <= vds_start_i;
            dac_load_q  <= 1'b1;
            state_q     <= LOAD;
          end
          LOAD: begin
            set_cnt_q   <= settle_q - SETTLE_W'(1);
            adc_start_q <= settle_q == '0;
            state_q     <= (settle_q != '0) ? SETTLE : CONV;
          end
          SETTLE: if (set_cnt_q == '0) begin
            adc_start_q <= 1'b1;
            state_q     <= CONV;
          end else begin
            set_cnt_q <= set_cnt_q - SETTLE_W'(1);
          end
          CONV: begin
            tmo_q   <= '0;
            state_q <= WAIT;
          end
          WAIT: if (adc_done_i) begin
            acc_q <= acc_d;
            if (smp_last_d) begin
              res_id_q    <= ADC_W'(acc_d >>> avg_q);
              res_vgs_q   <= dac_vgs_q;
              res_vds_q   <= dac_vds_q;
              res_valid_q <= 1'b1;
              state_q     <= OUTPUT;
            end else begin
              smp_q       <= smp_q + SMP_W'(1);
              adc_start_q <= 1'b1;
              state_q     <= CONV;
            end
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            err_q      <= 1'b1;
            park_ok_q  <= 1'b0;
            dac_vgs_q  <= '0;
            dac_vds_q  <= '0;
            dac_load_q <= 1'b1;
            state_q    <= PARK;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
          OUTPUT: if (res_ready_i) begin
            res_valid_q <= 1'b0;
            acc_q       <= '0;
            smp_q       <= '0;
            state_q     <= NEXT;
          end
          NEXT: if (vds_idx_q != vds_last_q) begin
            vds_idx_q  <= vds_idx_q + CNT_W'(1);
            dac_vds_q  <= vds_nxt_d[DAC_W-1:0];
            sat_q      <= sat_q | vds_nxt_d[DAC_W];
            dac_load_q <= 1'b1;
            state_q    <= LOAD;
          end else if (vgs_idx_q != vgs_last_q) begin
            vds_idx_q  <= '0;
            vgs_idx_q  <= vgs_idx_q + CNT_W'(1);
            dac_vds_q  <= vds_start_q;
            dac_vgs_q  <= vgs_nxt_d[DAC_W-1:0];
            sat_q      <= sat_q | vgs_nxt_d[DAC_W];
            dac_load_q <= 1'b1;
            state_q    <= LOAD;
          end else begin
            park_ok_q  <= 1'b1;
            dac_vgs_q  <= '0;
            dac_vds_q  <= '0;
            dac_load_q <= 1'b1;
            state_q    <= PARK;
          end
          // An abort arriving while parking still suppresses the done pulse.
          PARK: begin
            done_q  <= park_ok_q && !abort_i;
            state_q <= (park_ok_q && !abort_i) ? DONE : IDLE;
          end
          DONE: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign dac_vgs_o     = dac_vgs_q;
  assign dac_vds_o     = dac_vds_q;
  assign dac_load_o    = dac_load_q;
  assign adc_start_o   = adc_start_q;
  assign res_valid_o   = res_valid_q;
  assign res_vgs_o     = res_vgs_q;
  assign res_vds_o     = res_vds_q;
  assign res_id_o      = res_id_q;
  assign busy_o        = state_q != IDLE;
  assign done_o        = done_q;
  assign err_timeout_o = err_q;
  assign sat_o         = sat_q;
endmodule

// File: doc/gfet_sweep_controller.md
Name: gfet_sweep_controller

Overview:
Digital sequencer for the GFET characterization bench. It steps the gate and drain bias DACs through a 2-D grid (outer loop Vgs, inner loop Vds). At each point it waits a programmable settle time, triggers the drain-current ADC, averages 2^k samples, and streams (vgs_code, vds_code, id_avg) records over a valid/ready interface. It sits between the bench register file and the bias-DAC/ADC front end driving the graphene_fet device under test.

Parameters:
DAC_W, 12, bias DAC code width (unsigned)
ADC_W, 16, ADC sample width (two's complement)
CNT_W, 10, width of grid point counts
SETTLE_W, 16, settle-cycle counter width
MAX_AVG_LOG2, 7, largest accepted avg_log2
TIMEOUT, 4096, cycles to wait for adc_done before error

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  begin sweep (accepted only in IDLE)
abort  in  1  terminate sweep
vgs_start / vds_start  in  DAC_W  first codes
vgs_step / vds_step  in  DAC_W  signed per-point increments
vgs_count / vds_count  in  CNT_W  points per axis (0 treated as 1)
settle_cycles  in  SETTLE_W  settle delay per point
avg_log2  in  3  samples per point = 2^avg_log2 (clamped to MAX_AVG_LOG2)
dac_vgs / dac_vds  out  DAC_W  bias codes
dac_load  out  1  one-cycle DAC update strobe
adc_start  out  1  one-cycle conversion request
adc_done  in  1  conversion complete, adc_data valid this cycle
adc_data  in  ADC_W  drain-current sample
res_valid  out  1  result record valid
res_ready  in  1  downstream accept
res_vgs / res_vds  out  DAC_W  codes of the point
res_id  out  ADC_W  averaged sample
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at normal completion
err_timeout  out  1  sticky; cleared by next accepted start
sat  out  1  sticky; a code saturated; cleared by next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. During reset, all outputs are 0 and the FSM is in IDLE.
- FSM states: IDLE, LOAD, SETTLE, CONV, WAIT, OUTPUT, NEXT, PARK, DONE.
- IDLE: when start=1, capture all config inputs into registers (later changes are ignored), clear err_timeout and sat, then go to LOAD. start in any other state is ignored.
- LOAD: drive point codes and pulse dac_load for 1 cycle. Next state is SETTLE if settle_cycles>0, else CONV.
- SETTLE: stay exactly settle_cycles cycles, then go to CONV.
- CONV: pulse adc_start for 1 cycle, then go to WAIT.
- WAIT: on adc_done, add sign-extended adc_data into the accumulator (width ADC_W+MAX_AVG_LOG2).
  - When 2^avg_log2 samples are accumulated, go to OUTPUT; otherwise go back to CONV.
  - adc_done seen outside WAIT is ignored.
  - If TIMEOUT cycles pass in WAIT without adc_done, set err_timeout and go to PARK.
- OUTPUT: res_id = accumulator arithmetically shifted right by avg_log2. Assert res_valid.
  - res_* hold stable while res_valid=1 and res_ready=0.
  - On handshake, drop res_valid the next cycle, clear the accumulator, and go to NEXT.
  - If res_ready is already high on entry, the record transfers in 1 cycle.
- NEXT: advance the Vds index.
  - If the Vds index wraps, reset the Vds code to vds_start and advance the Vgs index.
  - If both axes are on their last point, go to PARK; otherwise go to LOAD.
- Code arithmetic: code + signed step, computed at DAC_W+1 bits. A result below 0 clamps to 0; a result above 2^DAC_W-1 clamps to the max. Either clamp sets sat. The sweep continues after a clamp.
- PARK: set dac_vgs = dac_vds = 0, pulse dac_load for 1 cycle. Go to DONE after normal completion, or to IDLE after a timeout or abort.
- DONE: pulse done for 1 cycle, then go to IDLE.
- abort: in any non-IDLE state, abort=1 moves the FSM to PARK next cycle. It drops res_valid (a record not yet accepted is discarded) and no done pulse follows. abort has priority over all other events in the same cycle, including a res handshake and adc_done.
- Latency: from start to the first dac_load is 1 cycle. Minimum per point (settle 0, avg 1, adc_done 1 cycle after adc_start, ready high) is LOAD+CONV+WAIT+OUTPUT+NEXT = 5 cycles.

Test Plan:
- Basic grid: vgs 3 points (start 100, step 50), vds 2 points (start 0, step 200), settle 4, avg 1, ADC returns 1000. Expect 6 records, order (100,0),(100,200),(150,0),(150,200),(200,0),(200,200), all res_id=1000, then one PARK dac_load to 0, then done.
- Averaging: avg_log2=2, ADC returns -3,5,7,-1. Expect res_id=2; the accumulator must sign-extend negative samples.
- Backpressure: hold res_ready=0 for 10 cycles. Expect res_valid high and res_* unchanged throughout, no adc_start issued, and the record transfers exactly once.
- Saturation: vgs_start=4000, step=100, count 3 (DAC_W=12). Expect codes 4000, 4095, 4095, sat=1, and the sweep completes with done.
- Timeout: never assert adc_done. Expect err_timeout=1 after 4096 WAIT cycles, DACs parked to 0, return to IDLE, no done. A new start clears err_timeout.
- Abort/reset: abort during SETTLE and during OUTPUT with res_ready=0. Expect PARK next cycle, res_valid=0, no done. Assert rst_n mid-WAIT: all outputs go to 0 immediately.
